// File: rtl/vic_pkg.sv
// vic_pkg: shared PC width, defaults and next-PC source encoding for the vector/PC path.
package vic_pkg;
  localparam int PC_W = 32;
  localparam int DEF_PC_STEP = 4;
  localparam logic [PC_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int DEF_STACK_DEPTH = 4;
  typedef enum logic [1:0] {SEQ, BRANCH, VECTOR, RETI} pc_src_e;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO; simultaneous push and pop leave the pointer alone.
module ret_stack
  import vic_pkg::*;
#(
  parameter int DEPTH = DEF_STACK_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_din,
  output logic [PC_W-1:0] o_top,
  output logic            o_full,
  output logic            o_empty,
  output logic [2:0]      o_count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [PC_W-1:0] r_mem [DEPTH];
  logic [2:0]      r_cnt;
  logic [AW-1:0]   w_wr_idx, w_rd_idx;
  logic            w_do_push, w_do_pop;
  assign w_wr_idx  = AW'(r_cnt);
  assign w_rd_idx  = AW'(r_cnt - 3'd1);
  assign w_do_push = i_push && !i_pop && !o_full;
  assign w_do_pop  = i_pop && !i_push && !o_empty;
  assign o_full    = r_cnt == 3'(DEPTH);
  assign o_empty   = r_cnt == 3'd0;
  assign o_count   = r_cnt;
  assign o_top     = r_mem[w_rd_idx];
  // Entry contents need no reset; occupancy alone defines validity.
  always_ff @(posedge i_clk)
    if (w_do_push) r_mem[w_wr_idx] <= i_din;
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) r_cnt <= 3'd0;
    else r_cnt <= w_do_push ? r_cnt + 3'd1 : w_do_pop ? r_cnt - 3'd1 : r_cnt;
endmodule

// File: rtl/irq_pc_unit.sv
// irq_pc_unit: fetch PC sequencer with vectored interrupt entry, nested return stack
// and sticky overflow/underflow flags.
module irq_pc_unit
  import vic_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = DEF_RESET_PC,
  parameter int              PC_STEP     = DEF_PC_STEP,
  parameter int              STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_PC_stall,
  input  logic            i_branch_en,
  input  logic [PC_W-1:0] i_branch_addr,
  input  logic            i_VIC_PC_ctrl,
  input  logic [PC_W-1:0] i_VIC_iaddr,
  input  logic            i_reti,
  input  logic            i_clr_err,
  output logic [PC_W-1:0] o_PC,
  output logic            o_int_ack,
  output logic [2:0]      o_nest_level,
  output logic            o_in_isr,
  output logic            o_stack_ovf,
  output logic            o_stack_unf
);
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_top, w_seq;
  logic            r_ack, r_ovf, r_unf;
  logic            w_full, w_empty, w_run, w_vec_acc, w_push, w_pop, w_ovf_set, w_unf_set, w_clr;
  pc_src_e         w_src;
  assign w_run     = !i_PC_stall;
  assign w_seq     = r_pc + PC_W'(PC_STEP);
  assign w_vec_acc = w_run && i_VIC_PC_ctrl && (i_reti || !w_full);
  assign w_push    = w_run && i_VIC_PC_ctrl && !i_reti && !w_full;
  assign w_pop     = w_run && !i_VIC_PC_ctrl && i_reti && !w_empty;
  assign w_ovf_set = w_run && i_VIC_PC_ctrl && !i_reti && w_full;
  assign w_unf_set = w_run && !i_VIC_PC_ctrl && i_reti && w_empty;
  assign w_clr     = w_run && i_clr_err;
  // Refused vectors and empty-stack returns fall through to the sequential/branch path.
  always_comb begin
    w_src    = w_vec_acc ? VECTOR : w_pop ? RETI : i_branch_en ? BRANCH : SEQ;
    w_pc_nxt = !w_run ? r_pc : w_src == VECTOR ? i_VIC_iaddr : w_src == RETI ? w_top :
               w_src == BRANCH ? i_branch_addr : w_seq;
  end
  ret_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_branch_en ? i_branch_addr : w_seq),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_nest_level)
  );
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      r_pc  <= RESET_PC;
      r_ack <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_ack <= w_vec_acc;
      r_ovf <= (r_ovf && !w_clr) || w_ovf_set;
      r_unf <= (r_unf && !w_clr) || w_unf_set;
    end
  assign o_PC        = r_pc;
  assign o_int_ack   = r_ack;
  assign o_in_isr    = o_nest_level != 3'd0;
  assign o_stack_ovf = r_ovf;
  assign o_stack_unf = r_unf;
endmodule

// File: tb/tb_irq_pc_unit.sv
// tb_irq_pc_unit: directed vector table, hand sequences and a queue-based random model.
module tb_irq_pc_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall = 0, br = 0, vic = 0, reti = 0, clr = 0;
  logic [31:0] ba = 0, ia = 0;
  logic [31:0] pc;
  logic        ack, in_isr, ovf, unf;
  logic [2:0]  lvl;
  int checks = 0, errors = 0;

  irq_pc_unit dut (
    .i_clk(clk), .i_rst(rst_n), .i_PC_stall(stall), .i_branch_en(br), .i_branch_addr(ba),
    .i_VIC_PC_ctrl(vic), .i_VIC_iaddr(ia), .i_reti(reti), .i_clr_err(clr),
    .o_PC(pc), .o_int_ack(ack), .o_nest_level(lvl), .o_in_isr(in_isr),
    .o_stack_ovf(ovf), .o_stack_unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stall, vic; logic [31:0] ia; logic reti, br; logic [31:0] ba; logic clr;
    logic [31:0] e_pc; logic [2:0] e_lvl; logic e_ack, e_ovf, e_unf;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [2:0] e_lvl,
                         input logic e_ack, input logic e_ovf, input logic e_unf);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".lvl"}, 32'(lvl), 32'(e_lvl));
    chk({tag, ".isr"}, 32'(in_isr), 32'(e_lvl != 0));
    chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
    chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
    chk({tag, ".unf"}, 32'(unf), 32'(e_unf));
  endtask

  task automatic drive(input logic s, input logic v, input logic [31:0] a, input logic r,
                       input logic b, input logic [31:0] bad, input logic c);
    stall = s; vic = v; ia = a; reti = r; br = b; ba = bad; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic add(input logic s, v, input logic [31:0] a, input logic r, b,
                     input logic [31:0] bad, input logic c, input logic [31:0] epc,
                     input logic [2:0] el, input logic eack, eovf, eunf);
    vec_t t;
    t = '{s, v, a, r, b, bad, c, epc, el, eack, eovf, eunf};
    tbl.push_back(t);
  endtask

  // Reference model state: return addresses kept in a plain queue.
  logic [31:0] m_pc; logic [31:0] m_q[$]; logic m_ack, m_ovf, m_unf;

  task automatic model_step();
    logic [31:0] ns;
    ns = br ? ba : m_pc + 32'd4;
    if (stall) begin
      m_ack = 0;
      return;
    end
    m_ack = 0;
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (vic) begin
      if (reti) begin m_pc = ia; m_ack = 1; end
      else if (m_q.size() < 4) begin m_q.push_back(ns); m_pc = ia; m_ack = 1; end
      else begin m_ovf = 1; m_pc = ns; end
    end else if (reti) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin m_unf = 1; m_pc = ns; end
    end else m_pc = ns;
  endtask

  initial begin
    //  stall vic ia           reti br ba            clr  e_pc          lvl ack ovf unf
    add(0, 0, 0,            0, 0, 0,            0, 32'h4,        0, 0, 0, 0);
    add(0, 0, 0,            0, 0, 0,            0, 32'h8,        0, 0, 0, 0);
    add(0, 0, 0,            0, 0, 0,            0, 32'hC,        0, 0, 0, 0);
    add(0, 0, 0,            0, 0, 0,            0, 32'h10,       0, 0, 0, 0);
    add(0, 1, 32'h200,      0, 0, 0,            0, 32'h200,      1, 1, 0, 0);
    add(0, 0, 0,            0, 0, 0,            0, 32'h204,      1, 0, 0, 0);
    add(0, 0, 0,            1, 0, 0,            0, 32'h14,       0, 0, 0, 0);
    add(0, 1, 32'h200,      0, 1, 32'h80,       0, 32'h200,      1, 1, 0, 0);
    add(0, 0, 0,            1, 0, 0,            0, 32'h80,       0, 0, 0, 0);
    add(0, 1, 32'h300,      0, 0, 0,            0, 32'h300,      1, 1, 0, 0);
    add(0, 1, 32'h400,      0, 0, 0,            0, 32'h400,      2, 1, 0, 0);
    add(0, 1, 32'h500,      0, 0, 0,            0, 32'h500,      3, 1, 0, 0);
    add(0, 1, 32'h600,      0, 0, 0,            0, 32'h600,      4, 1, 0, 0);
    add(0, 1, 32'h700,      0, 0, 0,            0, 32'h604,      4, 0, 1, 0);
    add(0, 0, 0,            0, 0, 0,            1, 32'h608,      4, 0, 0, 0);
    add(0, 0, 0,            1, 0, 0,            0, 32'h504,      3, 0, 0, 0);
    add(0, 0, 0,            1, 0, 0,            0, 32'h404,      2, 0, 0, 0);
    add(0, 1, 32'h900,      1, 0, 0,            0, 32'h900,      2, 1, 0, 0);
    add(0, 0, 0,            1, 0, 0,            0, 32'h304,      1, 0, 0, 0);
    add(0, 0, 0,            1, 0, 0,            0, 32'h84,       0, 0, 0, 0);
    add(0, 0, 0,            1, 0, 0,            0, 32'h88,       0, 0, 0, 1);
    add(0, 0, 0,            1, 0, 0,            1, 32'h8C,       0, 0, 0, 1);
    add(0, 0, 0,            0, 0, 0,            1, 32'h90,       0, 0, 0, 0);
    add(0, 0, 0,            0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0, 0, 0);
    add(0, 0, 0,            0, 0, 0,            0, 32'h0,        0, 0, 0, 0);
    add(0, 0, 32'hDEAD_BEE0, 0, 0, 0,           0, 32'h4,        0, 0, 0, 0);
    add(1, 1, 32'hA00,      0, 0, 0,            0, 32'h4,        0, 0, 0, 0);
    add(1, 1, 32'hA00,      0, 0, 0,            0, 32'h4,        0, 0, 0, 0);
    add(1, 1, 32'hA00,      0, 0, 0,            0, 32'h4,        0, 0, 0, 0);
    add(0, 1, 32'hA00,      0, 0, 0,            0, 32'hA00,      1, 1, 0, 0);
    add(1, 1, 32'hB00,      0, 0, 0,            0, 32'hA00,      1, 0, 0, 0);
    add(0, 1, 32'hB00,      0, 0, 0,            0, 32'hB00,      2, 1, 0, 0);

    #12;
    chk_all("reset", 32'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].vic, tbl[i].ia, tbl[i].reti, tbl[i].br, tbl[i].ba, tbl[i].clr);
      chk_all($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_lvl, tbl[i].e_ack, tbl[i].e_ovf, tbl[i].e_unf);
    end

    // Stall must freeze flags too, including a pending clear.
    drive(0, 1, 32'hC00, 0, 0, 0, 0);
    drive(0, 1, 32'hD00, 0, 0, 0, 0);
    drive(0, 1, 32'hE00, 0, 0, 0, 0);
    chk_all("ovf_set", 32'hD04, 4, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    chk_all("stall_clr", 32'hD04, 4, 0, 1, 0);

    // Asynchronous reset mid-ISR, checked between edges.
    stall = 0; vic = 0; reti = 0; clr = 0; br = 0;
    #2 rst_n = 0;
    #1 chk_all("async_rst", 32'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1;
    chk_all("rst_release", 32'h0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_all("post_rst", 32'h4, 0, 0, 0, 0);

    m_pc = 32'h4; m_q.delete(); m_ack = 0; m_ovf = 0; m_unf = 0;
    for (int n = 0; n < 500; n++) begin
      stall = $urandom_range(0, 99) < 15;
      vic   = $urandom_range(0, 99) < 30;
      reti  = $urandom_range(0, 99) < 25;
      br    = $urandom_range(0, 99) < 20;
      clr   = $urandom_range(0, 99) < 10;
      ia    = $urandom & 32'hFFFF_FFFC;
      ba    = $urandom & 32'hFFFF_FFFC;
      model_step();
      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", n), m_pc, 3'(m_q.size()), m_ack, m_ovf, m_unf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
